// File: rtl/execute.sv
// -----------------------------------------------------------------------------
// execute
//   Pipeline stage between decode and loadstore. Evaluates the integer ALU
//   operation, resolves branches/jumps and registers one result per accepted
//   instruction. Taken branches produce a one-cycle redirect pulse.
//
// Ports
//   clk_i, rst_ni                 clock / asynchronous active-low reset
//   input_valid_i, input_ready_o  handshake from decode
//   pc_i, alu_*_i                 instruction address, operands, ALU controls
//   branch_cond_i, branch_offset_i  branch condition and signed byte offset
//   ls_*_i                        load/store attributes, passed through
//   reg_write_i, reg_addr_i       destination register, passed through
//   output_ready_i, output_valid_o  handshake towards loadstore
//   alu_result_o                  ALU result / address / link value
//   enable_o .. unsigned_load_o   registered ls_* copies
//   reg_write_o, reg_addr_o       registered destination register
//   branch_o, branch_target_o     redirect pulse and target
// -----------------------------------------------------------------------------
module execute (
   input  logic        clk_i,
   input  logic        rst_ni,
   output logic        input_ready_o,
   input  logic        input_valid_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] alu_operand1_i,
   input  logic [31:0] alu_operand2_i,
   input  logic [2:0]  alu_op_i,
   input  logic        alu_sub_i,
   input  logic        alu_shift_left_i,
   input  logic        alu_signed_shift_i,
   input  logic [2:0]  branch_cond_i,
   input  logic [19:0] branch_offset_i,
   input  logic        ls_enable_i,
   input  logic        ls_write_i,
   input  logic [31:0] ls_write_data_i,
   input  logic [3:0]  ls_sel_i,
   input  logic        ls_unsigned_load_i,
   input  logic        reg_write_i,
   input  logic [4:0]  reg_addr_i,
   input  logic        output_ready_i,
   output logic        output_valid_o,
   output logic [31:0] alu_result_o,
   output logic        enable_o,
   output logic        write_o,
   output logic [31:0] write_data_o,
   output logic [3:0]  sel_o,
   output logic        unsigned_load_o,
   output logic        reg_write_o,
   output logic [4:0]  reg_addr_o,
   output logic        branch_o,
   output logic [31:0] branch_target_o
);

   logic        ready_en_q;   // low in reset and the first cycle after release
   logic        flush_q;      // cycle following a redirect: wrong-path slot
   logic        accept;
   logic [31:0] alu_val;
   logic [31:0] add_sum;
   logic [4:0]  shamt;
   logic        eq, lt, ltu;
   logic        taken;
   logic [31:0] target;
   logic [31:0] result;

   assign input_ready_o = ready_en_q && !flush_q && (!output_valid_o || output_ready_i);
   assign accept        = input_valid_i && input_ready_o;

   assign add_sum = alu_operand1_i + alu_operand2_i;
   assign shamt   = alu_operand2_i[4:0];
   assign eq      = (alu_operand1_i == alu_operand2_i);
   assign lt      = ($signed(alu_operand1_i) < $signed(alu_operand2_i));
   assign ltu     = (alu_operand1_i < alu_operand2_i);

   always_comb begin
      alu_val = '0;
      case (alu_op_i)
         3'd0: alu_val = alu_sub_i ? (alu_operand1_i - alu_operand2_i) : add_sum;
         3'd1: alu_val = alu_operand1_i ^ alu_operand2_i;
         3'd2: alu_val = alu_operand1_i | alu_operand2_i;
         3'd3: alu_val = alu_operand1_i & alu_operand2_i;
         3'd4: alu_val = {31'b0, lt};
         3'd5: alu_val = {31'b0, ltu};
         3'd6: begin
            if (alu_shift_left_i)
               alu_val = alu_operand1_i << shamt;
            else if (alu_signed_shift_i)
               alu_val = $signed(alu_operand1_i) >>> shamt;
            else
               alu_val = alu_operand1_i >> shamt;
         end
         default: alu_val = '0;
      endcase
   end

   always_comb begin
      taken = 1'b0;
      case (branch_cond_i)
         3'd1: taken = eq;
         3'd2: taken = !eq;
         3'd3: taken = lt;
         3'd4: taken = !lt;
         3'd5: taken = ltu;
         3'd6: taken = !ltu;
         3'd7: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   // Jumps use the ALU sum as target and return the link address as result.
   always_comb begin
      if (branch_cond_i == 3'd7) begin
         target = add_sum & ~32'd1;
         result = pc_i + 32'd4;
      end else begin
         target = pc_i + {{12{branch_offset_i[19]}}, branch_offset_i};
         result = alu_val;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ready_en_q      <= 1'b0;
         flush_q         <= 1'b0;
         output_valid_o  <= 1'b0;
         alu_result_o    <= '0;
         enable_o        <= 1'b0;
         write_o         <= 1'b0;
         write_data_o    <= '0;
         sel_o           <= '0;
         unsigned_load_o <= 1'b0;
         reg_write_o     <= 1'b0;
         reg_addr_o      <= '0;
         branch_o        <= 1'b0;
         branch_target_o <= '0;
      end else begin
         ready_en_q <= 1'b1;
         flush_q    <= branch_o;
         // Pulse only on the accepting edge, so a stalled output never repeats it.
         branch_o   <= accept && taken;
         if (accept) begin
            output_valid_o  <= 1'b1;
            alu_result_o    <= result;
            enable_o        <= ls_enable_i;
            write_o         <= ls_write_i;
            write_data_o    <= ls_write_data_i;
            sel_o           <= ls_sel_i;
            unsigned_load_o <= ls_unsigned_load_i;
            reg_write_o     <= reg_write_i;
            reg_addr_o      <= reg_addr_i;
            if (taken)
               branch_target_o <= target;
         end else if (output_ready_i) begin
            output_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_execute.sv
module tb_execute;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        input_ready_o;
   logic        input_valid_i;
   logic [31:0] pc_i;
   logic [31:0] alu_operand1_i;
   logic [31:0] alu_operand2_i;
   logic [2:0]  alu_op_i;
   logic        alu_sub_i;
   logic        alu_shift_left_i;
   logic        alu_signed_shift_i;
   logic [2:0]  branch_cond_i;
   logic [19:0] branch_offset_i;
   logic        ls_enable_i;
   logic        ls_write_i;
   logic [31:0] ls_write_data_i;
   logic [3:0]  ls_sel_i;
   logic        ls_unsigned_load_i;
   logic        reg_write_i;
   logic [4:0]  reg_addr_i;
   logic        output_ready_i;
   logic        output_valid_o;
   logic [31:0] alu_result_o;
   logic        enable_o;
   logic        write_o;
   logic [31:0] write_data_o;
   logic [3:0]  sel_o;
   logic        unsigned_load_o;
   logic        reg_write_o;
   logic [4:0]  reg_addr_o;
   logic        branch_o;
   logic [31:0] branch_target_o;

   int unsigned errors = 0;
   int unsigned checks = 0;

   execute dut (
      .clk_i              (clk_i),
      .rst_ni             (rst_ni),
      .input_ready_o      (input_ready_o),
      .input_valid_i      (input_valid_i),
      .pc_i               (pc_i),
      .alu_operand1_i     (alu_operand1_i),
      .alu_operand2_i     (alu_operand2_i),
      .alu_op_i           (alu_op_i),
      .alu_sub_i          (alu_sub_i),
      .alu_shift_left_i   (alu_shift_left_i),
      .alu_signed_shift_i (alu_signed_shift_i),
      .branch_cond_i      (branch_cond_i),
      .branch_offset_i    (branch_offset_i),
      .ls_enable_i        (ls_enable_i),
      .ls_write_i         (ls_write_i),
      .ls_write_data_i    (ls_write_data_i),
      .ls_sel_i           (ls_sel_i),
      .ls_unsigned_load_i (ls_unsigned_load_i),
      .reg_write_i        (reg_write_i),
      .reg_addr_i         (reg_addr_i),
      .output_ready_i     (output_ready_i),
      .output_valid_o     (output_valid_o),
      .alu_result_o       (alu_result_o),
      .enable_o           (enable_o),
      .write_o            (write_o),
      .write_data_o       (write_data_o),
      .sel_o              (sel_o),
      .unsigned_load_o    (unsigned_load_o),
      .reg_write_o        (reg_write_o),
      .reg_addr_o         (reg_addr_o),
      .branch_o           (branch_o),
      .branch_target_o    (branch_target_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_in();
      input_valid_i      = 1'b0;
      pc_i               = '0;
      alu_operand1_i     = '0;
      alu_operand2_i     = '0;
      alu_op_i           = '0;
      alu_sub_i          = 1'b0;
      alu_shift_left_i   = 1'b0;
      alu_signed_shift_i = 1'b0;
      branch_cond_i      = '0;
      branch_offset_i    = '0;
      ls_enable_i        = 1'b0;
      ls_write_i         = 1'b0;
      ls_write_data_i    = '0;
      ls_sel_i           = '0;
      ls_unsigned_load_i = 1'b0;
      reg_write_i        = 1'b0;
      reg_addr_i         = '0;
   endtask

   task automatic alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      clear_in();
      input_valid_i  = 1'b1;
      alu_op_i       = op;
      alu_operand1_i = a;
      alu_operand2_i = b;
   endtask

   initial begin
      rst_ni = 1'b0;
      output_ready_i = 1'b0;
      clear_in();

      // reset state
      repeat (2) @(negedge clk_i);
      chk("rst_valid", {31'b0, output_valid_o}, 32'd0);
      chk("rst_ready", {31'b0, input_ready_o}, 32'd0);
      chk("rst_result", alu_result_o, 32'd0);
      chk("rst_branch", {31'b0, branch_o}, 32'd0);
      rst_ni = 1'b1;
      #1 chk("rel_ready_low", {31'b0, input_ready_o}, 32'd0);
      @(negedge clk_i);
      chk("rel_ready_high", {31'b0, input_ready_o}, 32'd1);

      // ADD overflow then SUB underflow, back to back
      output_ready_i = 1'b1;
      alu(3'd0, 32'h7FFF_FFFF, 32'h1);
      reg_write_i = 1'b1;
      reg_addr_i  = 5'd5;
      @(negedge clk_i);
      chk("add_valid", {31'b0, output_valid_o}, 32'd1);
      chk("add_result", alu_result_o, 32'h8000_0000);
      chk("add_rd", {27'b0, reg_addr_o}, 32'd5);
      chk("add_we", {31'b0, reg_write_o}, 32'd1);
      alu(3'd0, 32'h0, 32'h1);
      alu_sub_i = 1'b1;
      @(negedge clk_i);
      chk("sub_result", alu_result_o, 32'hFFFF_FFFF);
      chk("sub_we", {31'b0, reg_write_o}, 32'd0);
      clear_in();
      @(negedge clk_i);
      chk("drain_valid", {31'b0, output_valid_o}, 32'd0);

      // shifts and compares
      alu(3'd6, 32'h8000_0000, 32'h24);
      alu_signed_shift_i = 1'b1;
      @(negedge clk_i);
      chk("sra", alu_result_o, 32'hF800_0000);
      alu(3'd6, 32'h8000_0000, 32'h24);
      @(negedge clk_i);
      chk("srl", alu_result_o, 32'h0800_0000);
      alu(3'd6, 32'h3, 32'h21);
      alu_shift_left_i = 1'b1;
      @(negedge clk_i);
      chk("sll", alu_result_o, 32'h6);
      alu(3'd4, 32'hFFFF_FFFF, 32'h1);
      @(negedge clk_i);
      chk("slt", alu_result_o, 32'h1);
      alu(3'd5, 32'hFFFF_FFFF, 32'h1);
      @(negedge clk_i);
      chk("sltu", alu_result_o, 32'h0);
      alu(3'd1, 32'hF0F0, 32'hFF00);
      @(negedge clk_i);
      chk("xor", alu_result_o, 32'h0FF0);
      alu(3'd2, 32'hF0F0, 32'hFF00);
      @(negedge clk_i);
      chk("or", alu_result_o, 32'hFFF0);
      alu(3'd3, 32'hF0F0, 32'hFF00);
      @(negedge clk_i);
      chk("and", alu_result_o, 32'hF000);
      alu(3'd7, 32'h1234, 32'h5678);
      @(negedge clk_i);
      chk("op7", alu_result_o, 32'h0);
      chk("op7_branch", {31'b0, branch_o}, 32'd0);

      // BLT taken, then wrong-path slot
      alu(3'd0, 32'hFFFF_FFFE, 32'h3);
      pc_i            = 32'h100;
      branch_cond_i   = 3'd3;
      branch_offset_i = 20'hFFFF0;
      @(negedge clk_i);
      chk("blt_branch", {31'b0, branch_o}, 32'd1);
      chk("blt_target", branch_target_o, 32'h0F0);
      chk("blt_result", alu_result_o, 32'h1);
      chk("blt_valid", {31'b0, output_valid_o}, 32'd1);
      clear_in();
      @(negedge clk_i);
      chk("blt_pulse_end", {31'b0, branch_o}, 32'd0);
      chk("flush_ready", {31'b0, input_ready_o}, 32'd0);
      alu(3'd0, 32'h1, 32'h1);
      reg_addr_i = 5'd9;
      @(negedge clk_i);
      chk("flush_discard", {31'b0, output_valid_o}, 32'd0);
      chk("flush_ready_back", {31'b0, input_ready_o}, 32'd1);

      // BEQ not taken: target holds
      alu(3'd0, 32'h1, 32'h2);
      branch_cond_i = 3'd1;
      pc_i          = 32'h400;
      @(negedge clk_i);
      chk("beq_nt_branch", {31'b0, branch_o}, 32'd0);
      chk("beq_nt_target", branch_target_o, 32'h0F0);
      chk("beq_nt_result", alu_result_o, 32'h3);

      // JUMP with link
      alu(3'd0, 32'h1001, 32'h4);
      pc_i          = 32'h200;
      branch_cond_i = 3'd7;
      reg_write_i   = 1'b1;
      reg_addr_i    = 5'd1;
      @(negedge clk_i);
      chk("jmp_branch", {31'b0, branch_o}, 32'd1);
      chk("jmp_target", branch_target_o, 32'h1004);
      chk("jmp_link", alu_result_o, 32'h204);
      chk("jmp_we", {31'b0, reg_write_o}, 32'd1);
      chk("jmp_rd", {27'b0, reg_addr_o}, 32'd1);
      clear_in();
      @(negedge clk_i);
      chk("jmp_flush_ready", {31'b0, input_ready_o}, 32'd0);
      @(negedge clk_i);

      // store held under backpressure
      alu(3'd0, 32'h1000, 32'h8);
      ls_enable_i     = 1'b1;
      ls_write_i      = 1'b1;
      ls_write_data_i = 32'hDEAD_BEEF;
      ls_sel_i        = 4'hF;
      @(negedge clk_i);
      chk("st_valid", {31'b0, output_valid_o}, 32'd1);
      chk("st_addr", alu_result_o, 32'h1008);
      chk("st_en_wr_sel", {26'b0, enable_o, write_o, sel_o}, {26'b0, 2'b11, 4'hF});
      chk("st_data", write_data_o, 32'hDEAD_BEEF);
      output_ready_i = 1'b0;
      alu(3'd0, 32'h5, 32'h5);
      reg_addr_i = 5'd3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("stall_ready", {31'b0, input_ready_o}, 32'd0);
         chk("stall_valid", {31'b0, output_valid_o}, 32'd1);
         chk("stall_addr", alu_result_o, 32'h1008);
         chk("stall_data", write_data_o, 32'hDEAD_BEEF);
         chk("stall_en", {31'b0, enable_o}, 32'd1);
      end
      output_ready_i = 1'b1;
      #1 chk("resume_ready", {31'b0, input_ready_o}, 32'd1);
      @(negedge clk_i);
      chk("resume_result", alu_result_o, 32'hA);
      chk("resume_en", {31'b0, enable_o}, 32'd0);
      chk("resume_rd", {27'b0, reg_addr_o}, 32'd3);

      // taken branch then stall: pulse not repeated
      alu(3'd0, 32'h1, 32'h2);
      branch_cond_i   = 3'd2;
      pc_i            = 32'h300;
      branch_offset_i = 20'h00010;
      @(negedge clk_i);
      chk("bne_branch", {31'b0, branch_o}, 32'd1);
      chk("bne_target", branch_target_o, 32'h310);
      clear_in();
      output_ready_i = 1'b0;
      @(negedge clk_i);
      chk("bne_stall_pulse", {31'b0, branch_o}, 32'd0);
      chk("bne_stall_valid", {31'b0, output_valid_o}, 32'd1);
      @(negedge clk_i);
      chk("bne_stall_pulse2", {31'b0, branch_o}, 32'd0);

      // asynchronous reset while holding a stalled result
      #2 rst_ni = 1'b0;
      #1;
      chk("arst_valid", {31'b0, output_valid_o}, 32'd0);
      chk("arst_result", alu_result_o, 32'd0);
      chk("arst_target", branch_target_o, 32'd0);
      chk("arst_ready", {31'b0, input_ready_o}, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      output_ready_i = 1'b1;
      #1 chk("arst_rel_ready_low", {31'b0, input_ready_o}, 32'd0);
      @(negedge clk_i);
      chk("arst_rel_ready_high", {31'b0, input_ready_o}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
